// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - time-multiplexed leaky integrate-and-fire neuron array
// One shared leak/integrate/threshold datapath updates the addressed neuron per accepted event.
module lif_neuron_array #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 8,
  parameter int IDX_W     = 3,
  parameter int REFRAC_W  = 3,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    cfg_threshold,
  input  logic [2:0]          cfg_leak_shift,
  input  logic [REFRAC_W-1:0] cfg_refrac,
  input  logic                cfg_sub_reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDX_W-1:0]    in_idx,
  input  logic [WIDTH-1:0]    in_current,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_spike,
  output logic [WIDTH-1:0]    out_state,
  output logic [CNT_W-1:0]    spike_count
);

  logic [WIDTH-1:0]    state_q  [N_NEURONS];
  logic [WIDTH-1:0]    state_d  [N_NEURONS];
  logic [REFRAC_W-1:0] refrac_q [N_NEURONS];
  logic [REFRAC_W-1:0] refrac_d [N_NEURONS];
  logic                out_valid_q, out_valid_d;
  logic                out_spike_q, out_spike_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic [WIDTH-1:0]    out_state_q, out_state_d;
  logic [CNT_W-1:0]    spike_count_q, spike_count_d;

  logic                accept, idx_ok, fire;
  logic [IDX_W-1:0]    rd_idx;
  logic [WIDTH-1:0]    cur_state, leaked, sum, fire_state;
  logic [REFRAC_W-1:0] cur_refrac;
  logic [WIDTH:0]      sum_wide;

  assign in_ready   = !out_valid_q | out_ready;
  assign accept     = in_valid & in_ready;
  assign idx_ok     = int'(in_idx) < N_NEURONS;
  // Out-of-range indices are steered to entry 0 for the read; the write is suppressed below.
  assign rd_idx     = idx_ok ? in_idx : '0;
  assign cur_state  = state_q[rd_idx];
  assign cur_refrac = refrac_q[rd_idx];
  assign leaked     = cur_state >> cfg_leak_shift;
  assign sum_wide   = {1'b0, leaked} + {1'b0, in_current};
  assign sum        = sum_wide[WIDTH] ? '1 : sum_wide[WIDTH-1:0];
  assign fire       = sum >= cfg_threshold;
  assign fire_state = cfg_sub_reset ? sum - cfg_threshold : '0;

  always_comb begin
    state_d       = state_q;
    refrac_d      = refrac_q;
    out_valid_d   = out_valid_q;
    out_spike_d   = out_spike_q;
    out_idx_d     = out_idx_q;
    out_state_d   = out_state_q;
    spike_count_d = spike_count_q;
    if (clear) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_d[i]  = '0;
        refrac_d[i] = '0;
      end
      out_valid_d   = 1'b0;
      spike_count_d = '0;
    end else begin
      if (out_ready) out_valid_d = 1'b0;
      if (accept && idx_ok) begin
        out_valid_d = 1'b1;
        out_idx_d   = in_idx;
        if (cur_refrac != '0) begin
          refrac_d[rd_idx] = cur_refrac - REFRAC_W'(1);
          out_spike_d      = 1'b0;
          out_state_d      = cur_state;
        end else if (fire) begin
          state_d[rd_idx]  = fire_state;
          refrac_d[rd_idx] = cfg_refrac;
          out_spike_d      = 1'b1;
          out_state_d      = fire_state;
          if (spike_count_q != '1) spike_count_d = spike_count_q + CNT_W'(1);
        end else begin
          state_d[rd_idx] = sum;
          out_spike_d     = 1'b0;
          out_state_d     = sum;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= '0;
        refrac_q[i] <= '0;
      end
      out_valid_q   <= 1'b0;
      out_spike_q   <= 1'b0;
      out_idx_q     <= '0;
      out_state_q   <= '0;
      spike_count_q <= '0;
    end else begin
      state_q       <= state_d;
      refrac_q      <= refrac_d;
      out_valid_q   <= out_valid_d;
      out_spike_q   <= out_spike_d;
      out_idx_q     <= out_idx_d;
      out_state_q   <= out_state_d;
      spike_count_q <= spike_count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_spike   = out_spike_q;
  assign out_idx     = out_idx_q;
  assign out_state   = out_state_q;
  assign spike_count = spike_count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - randomized and directed bench for lif_neuron_array
// Six neurons on a 3-bit index so out-of-range events are reachable; 4-bit counter to reach saturation.
module tb_lif_neuron_array;

  localparam int WIDTH = 8, N = 6, IDX_W = 3, RW = 3, CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic [WIDTH-1:0] cfg_threshold = '0;
  logic [2:0]       cfg_leak_shift = '0;
  logic [RW-1:0]    cfg_refrac = '0;
  logic             cfg_sub_reset = 1'b0, clear = 1'b0;
  logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_spike;
  logic [IDX_W-1:0] in_idx = '0, out_idx;
  logic [WIDTH-1:0] in_current = '0, out_state;
  logic [CW-1:0]    spike_count;

  lif_neuron_array #(.WIDTH(WIDTH), .N_NEURONS(N), .IDX_W(IDX_W), .REFRAC_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_threshold(cfg_threshold), .cfg_leak_shift(cfg_leak_shift),
    .cfg_refrac(cfg_refrac), .cfg_sub_reset(cfg_sub_reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx), .in_current(in_current),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_spike(out_spike),
    .out_state(out_state), .spike_count(spike_count));

  always #5 clk = ~clk;

  typedef struct { int idx; int spike; int state; } res_t;
  res_t exp_q[$];
  int   m_state[N], m_refrac[N], m_cnt;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_state[i] = 0; m_refrac[i] = 0; end
    m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_apply(input int idx, input int cur);
    res_t r;
    int   s;
    if (idx >= N) return;
    r.idx = idx;
    if (m_refrac[idx] > 0) begin
      m_refrac[idx]--;
      r.spike = 0;
    end else begin
      s = (m_state[idx] / (1 << cfg_leak_shift)) + cur;
      if (s > 255) s = 255;
      if (s >= int'(cfg_threshold)) begin
        m_state[idx]  = cfg_sub_reset ? s - int'(cfg_threshold) : 0;
        m_refrac[idx] = int'(cfg_refrac);
        r.spike = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end else begin
        m_state[idx] = s;
        r.spike = 0;
      end
    end
    r.state = m_state[idx];
    exp_q.push_back(r);
  endtask

  // Called at a negedge: drive inputs, check the visible outputs, predict, and advance one cycle.
  task automatic cycle(input int v, input int idx, input int cur, input int rdy, input int clr);
    res_t r;
    in_valid = v[0]; in_idx = idx[IDX_W-1:0]; in_current = cur[WIDTH-1:0];
    out_ready = rdy[0]; clear = clr[0];
    #1;
    check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
    check("in_ready", int'(in_ready), int'(exp_q.size() == 0 || rdy != 0));
    check("spike_count", int'(spike_count), m_cnt);
    if (out_valid && exp_q.size() != 0) begin
      r = exp_q[0];
      check("out_idx", int'(out_idx), r.idx);
      check("out_spike", int'(out_spike), r.spike);
      check("out_state", int'(out_state), r.state);
      if (rdy != 0) void'(exp_q.pop_front());
    end
    if (clr != 0) begin
      for (int i = 0; i < N; i++) begin m_state[i] = 0; m_refrac[i] = 0; end
      m_cnt = 0;
      exp_q.delete();
    end else if (v != 0 && (exp_q.size() == 0 || rdy != 0)) begin
      model_apply(idx, cur);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cfg(input int thr, input int sh, input int rf, input int sub);
    cfg_threshold = thr[WIDTH-1:0]; cfg_leak_shift = sh[2:0];
    cfg_refrac = rf[RW-1:0]; cfg_sub_reset = sub[0];
  endtask

  initial begin
    int h_state, h_idx, h_spike;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_state", int'(out_state), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_spike", int'(out_spike), 0);
    check("rst_spike_count", int'(spike_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Leak and integrate, then zero-reset fire
    cfg(32, 1, 0, 0);
    cycle(1, 2, 20, 1, 0); check("dir_s20", int'(out_state), 20);
    cycle(1, 2, 20, 1, 0); check("dir_s30", int'(out_state), 30);
    cycle(1, 2, 20, 1, 0); check("dir_fire", int'(out_spike), 1);
    check("dir_fire_state", int'(out_state), 0); check("dir_cnt1", int'(spike_count), 1);
    // Subtract reset
    cfg(32, 1, 0, 1);
    cycle(1, 0, 50, 1, 0); check("sub_state18", int'(out_state), 18);
    cycle(1, 0, 0, 1, 0);  check("sub_state9", int'(out_state), 9);
    check("sub_nospike", int'(out_spike), 0);
    // Refractory
    cfg(32, 1, 2, 0);
    cycle(1, 1, 40, 1, 0);  check("ref_fire", int'(out_spike), 1);
    cycle(1, 1, 200, 1, 0); check("ref_hold1", int'(out_spike), 0);
    cycle(1, 1, 200, 1, 0); check("ref_hold2_state", int'(out_state), 0);
    cycle(1, 1, 40, 1, 0);  check("ref_refire", int'(out_spike), 1);
    // Saturation: 200 + 100 clamps to 255, minus threshold 1
    cfg(255, 0, 0, 1);
    cycle(1, 3, 200, 1, 0); check("sat_s200", int'(out_state), 200);
    cfg(1, 0, 0, 1);
    cycle(1, 3, 100, 1, 0); check("sat_state", int'(out_state), 254);
    // Zero threshold fires every time; also drives the counter into saturation
    cfg(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(1, 4, i, 1, 0);
    check("thr0_spike", int'(out_spike), 1);
    cycle(0, 0, 0, 1, 0);
    check("cnt_sat", int'(spike_count), CNT_MAX);
    // Out-of-range indices are dropped
    cycle(1, N, 9, 1, 0);
    cycle(1, 7, 9, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("drop_no_valid", int'(out_valid), 0);
    // Clear wins over a simultaneous accept
    cycle(1, 5, 10, 1, 0);
    cycle(1, 5, 10, 1, 1);
    cycle(0, 0, 0, 1, 0);
    check("clear_cnt", int'(spike_count), 0);
    // Backpressure: five stalled cycles with outputs frozen
    cfg(100, 1, 0, 0);
    cycle(1, 2, 33, 1, 0);
    h_state = int'(out_state); h_idx = int'(out_idx); h_spike = int'(out_spike);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 3, 44 + i, 0, 0);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_state", int'(out_state), h_state);
      check("bp_idx", int'(out_idx), h_idx);
      check("bp_spike", int'(out_spike), h_spike);
    end
    for (int i = 0; i < 4; i++) cycle(1, i, 30 + i, 1, 0);
    cycle(0, 0, 0, 1, 0);
    // Asynchronous reset while a result is pending
    cycle(1, 2, 5, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_state", int'(out_state), 0);
    check("arst_idx", int'(out_idx), 0);
    check("arst_cnt", int'(spike_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cfg(255, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      cycle(1, i, 0, 1, 0);
      check("arst_neuron_zero", int'(out_state), 0);
    end
    cycle(0, 0, 0, 1, 0);

    // Randomized phase against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0)
        cfg($urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1));
      cycle(int'($urandom_range(0, 3) != 0), $urandom_range(0, 7), $urandom_range(0, 255),
            int'($urandom_range(0, 9) < 7), int'($urandom_range(0, 49) == 0));
    end
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
